modn_updown_counter: RTL

Parametrised modulo-N counter, successor to the fixed mod-9 counter. Adds configurable modulus and width, up/down counting, count enable, synchronous parallel load with range check, and a registered terminal-count pulse. Used as a cycle divider and sequence index in lab-level designs, and can be cascaded through tc_out.

---
 rtl/modn_updown_counter_pkg.sv | 16 +
 rtl/modn_updown_counter_if.sv | 38 +++
 rtl/modn_updown_counter_wrap_tracker.sv | 22 ++
 rtl/modn_updown_counter.sv | 67 ++++++
 4 files changed

// File: rtl/modn_updown_counter_pkg.sv
// Shared constants and the parameter legality check for the modulo-N up/down counter.
// Optional wrap counter is built when MODN_COUNTER_WRAP_CNT_EN is defined.
package modn_cnt_pkg;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   localparam int WRAP_CNT_W = 8;

   // MODULUS must have at least two states and must fit in WIDTH bits.
   function automatic bit modn_legal(input int modulus, input int width);
      if (width < 1 || width > 31) return 1'b0;
      return (modulus >= 2) && (longint'(modulus) <= (longint'(1) << width));
   endfunction

endpackage

// File: rtl/modn_updown_counter_if.sv
// Control/status bundle of the modulo-N counter.
// wrap_clr/wrap_cnt exist only when MODN_COUNTER_WRAP_CNT_EN is defined.
interface modn_updown_counter_if #(
   parameter int WIDTH = 4
) ();
   import modn_cnt_pkg::*;

   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tc_out;
   logic             load_err;
`ifdef MODN_COUNTER_WRAP_CNT_EN
   logic                  wrap_clr;
   logic [WRAP_CNT_W-1:0] wrap_cnt;
`endif

   modport master (
      output en, up_dn, load, load_val,
`ifdef MODN_COUNTER_WRAP_CNT_EN
      output wrap_clr,
      input  wrap_cnt,
`endif
      input  count, tc_out, load_err
   );

   modport slave (
      input  en, up_dn, load, load_val,
`ifdef MODN_COUNTER_WRAP_CNT_EN
      input  wrap_clr,
      output wrap_cnt,
`endif
      output count, tc_out, load_err
   );

endinterface

// File: rtl/modn_updown_counter_wrap_tracker.sv
// Saturating count of terminal-count pulses; used only with MODN_COUNTER_WRAP_CNT_EN.
module modn_wrap_tracker
   import modn_cnt_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  inc,
   output logic [WRAP_CNT_W-1:0] wrap_cnt
);

   // Clear beats increment; stick at all-ones once reached.
   always_ff @(posedge clk) begin
      if (!reset)
         wrap_cnt <= '0;
      else if (clr)
         wrap_cnt <= '0;
      else if (inc && (wrap_cnt != '1))
         wrap_cnt <= wrap_cnt + WRAP_CNT_W'(1);
   end

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with enable, range-checked load and registered
// terminal-count pulse. Define MODN_COUNTER_WRAP_CNT_EN to add the wrap counter.
module modn_updown_counter
   import modn_cnt_pkg::*;
#(
   parameter int MODULUS = 9,
   parameter int WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   modn_updown_counter_if.slave  bus
);

   if (!modn_legal(MODULUS, WIDTH)) begin : g_bad_param
      $fatal(1, "modn_updown_counter: MODULUS out of range for WIDTH");
   end

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

   logic at_top, at_bot, load_ok, wrap;

   // Compare one bit wider so MODULUS == 2**WIDTH accepts every load value.
   assign load_ok = ({1'b0, bus.load_val} < (WIDTH+1)'(MODULUS));
   assign at_top  = (bus.count == MAX);
   assign at_bot  = (bus.count == '0);
   // This edge wraps: counting (not loading) and sitting on the boundary for the current direction.
   assign wrap    = !bus.load && bus.en && ((bus.up_dn == DIR_UP) ? at_top : at_bot);

   // Core state: reset > load > count > hold; pulses default low on every non-event edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.count    <= '0;
         bus.tc_out   <= 1'b0;
         bus.load_err <= 1'b0;
      end else if (bus.load) begin
         bus.tc_out   <= 1'b0;
         bus.load_err <= !load_ok;
         bus.count    <= load_ok ? bus.load_val : MAX;
      end else if (bus.en) begin
         bus.tc_out   <= wrap;
         bus.load_err <= 1'b0;
         if (bus.up_dn == DIR_UP)
            bus.count <= at_top ? '0 : bus.count + WIDTH'(1);
         else
            bus.count <= at_bot ? MAX : bus.count - WIDTH'(1);
      end else begin
         bus.tc_out   <= 1'b0;
         bus.load_err <= 1'b0;
      end
   end

`ifdef MODN_COUNTER_WRAP_CNT_EN
   logic [WRAP_CNT_W-1:0] wrap_cnt;

   // Load also clears the tally; it never coincides with a wrap.
   modn_wrap_tracker u_wrap (
      .clk      (clk),
      .reset    (reset),
      .clr      (bus.wrap_clr | bus.load),
      .inc      (wrap),
      .wrap_cnt (wrap_cnt)
   );

   assign bus.wrap_cnt = wrap_cnt;
`endif

endmodule
